// File: rtl/byte_packer_pkg.sv
// Shared definitions for the byte stream blocks: packer FSM encoding and default word width.
package byte_packer_pkg;

  localparam int unsigned NBYTES_DEFAULT = 4;

  typedef enum logic [0:0] {
    StAcc,
    StPend
  } pack_state_e;

endpackage

// File: rtl/byte_packer_if.sv
// Byte-in / word-out stream bundle for the packer; master drives bytes, slave drives words.
interface byte_packer_if
  import byte_packer_pkg::*;
#(
  parameter int unsigned NBYTES = NBYTES_DEFAULT
) ();

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  in_flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_data;
  logic [NBYTES-1:0]     out_keep;

  modport master (
    output in_valid, in_data, in_flush, out_ready,
    input  in_ready, out_valid, out_data, out_keep
  );

  modport slave (
    input  in_valid, in_data, in_flush, out_ready,
    output in_ready, out_valid, out_data, out_keep
  );

endinterface

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into NBYTES-wide words with flush support and a
// single registered output slot; a flush blocked by a full slot waits in StPend.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int unsigned NBYTES = NBYTES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid_i,
  input  logic [7:0]          i_data_i,
  output logic                i_ready_o,
  input  logic                i_flush_i,
  output logic                e_valid_o,
  input  logic                e_ready_i,
  output logic [8*NBYTES-1:0] e_data_o,
  output logic [NBYTES-1:0]   e_keep_o
);

  localparam int unsigned CntW  = (NBYTES > 2) ? $clog2(NBYTES) : 1;
  localparam int unsigned DataW = 8 * NBYTES;
  localparam logic [CntW-1:0] CntLast = CntW'(NBYTES - 1);

  pack_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DataW-1:0]  acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [DataW-1:0]  out_data_q, out_data_d;
  logic [NBYTES-1:0] out_keep_q, out_keep_d;

  logic              slot_free;
  logic              ready;
  logic              accept;
  logic [DataW-1:0]  acc_with;
  int unsigned       fill;
  logic [NBYTES-1:0] fill_mask;

  always_comb begin
    slot_free = !out_valid_q || e_ready_i;
    ready     = (state_q == StAcc) && ((cnt_q != CntLast) || slot_free);
    accept    = i_valid_i && ready;

    acc_with = acc_q;
    if (accept) begin
      acc_with[8*int'(cnt_q) +: 8] = i_data_i;
    end

    // Bytes held after this cycle's accept; in StPend accept is 0 so this is just cnt.
    fill = 32'(cnt_q) + 32'(accept);
    for (int unsigned k = 0; k < NBYTES; k++) begin
      fill_mask[k] = (k < fill);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;

    if (out_valid_q && e_ready_i) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StAcc: begin
        if ((accept && (cnt_q == CntLast)) || (i_flush_i && (fill != 0))) begin
          if (slot_free) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_with;
            out_keep_d  = fill_mask;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            // Only a flush can get here: a full word is never accepted into a busy slot.
            state_d = StPend;
            acc_d   = acc_with;
            cnt_d   = CntW'(fill);
          end
        end else if (accept) begin
          acc_d = acc_with;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPend: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q;
          out_keep_d  = fill_mask;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StAcc;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
    end
  end

  assign i_ready_o = ready;
  assign e_valid_o = out_valid_q;
  assign e_data_o  = out_data_q;
  assign e_keep_o  = out_keep_q;

endmodule
